// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory arbiter: strobe encodings, owner enum, defaults.
package datamem_pkg;

    // Default arbitration limits
    localparam int unsigned DefStarveLimit = 4;
    localparam int unsigned DefMaxBurst    = 8;

    // Store strobe encoding: 000 word, {0,a1,1} half, {1,a1,a0} byte
    localparam logic [2:0] StrbWord   = 3'b000;
    localparam logic [2:0] StrbHalfLo = 3'b001;
    localparam logic [2:0] StrbHalfHi = 3'b011;
    localparam logic [2:0] StrbByte0  = 3'b100;
    localparam logic [2:0] StrbByte1  = 3'b101;
    localparam logic [2:0] StrbByte2  = 3'b110;
    localparam logic [2:0] StrbByte3  = 3'b111;

    // Which requester owns the memory port in a given cycle
    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerCore = 2'd1,
        OwnerExt  = 2'd2
    } owner_e;

endpackage

// File: rtl/datamem_arbiter.sv
// Single-port data memory arbiter between the core MEM stage and an external
// loader/debug port. Core has default priority; ext gets starvation relief and
// locked bursts that are periodically broken for one core cycle.
module datamem_arbiter
    import datamem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DefStarveLimit,
    parameter int unsigned MAX_BURST    = DefMaxBurst
) (
    input  logic        clk,
    input  logic        rst,
    // core side
    input  logic        core_req,
    input  logic        core_we,
    input  logic [6:0]  core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_strb,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    // external side
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic        ext_lock,
    input  logic [6:0]  ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [2:0]  ext_strb,
    output logic        ext_gnt,
    output logic [31:0] ext_rdata,
    output logic        ext_rvalid,
    // memory port
    output logic        mem_we0,
    output logic [6:0]  mem_rd_addr0,
    output logic [6:0]  mem_wr_addr0,
    output logic [31:0] mem_wr_din0,
    output logic [2:0]  mem_wr_strb,
    input  logic [31:0] mem_rd_dout0,
    // statistics
    output logic [15:0] stall_count
);

    // +2 keeps widths non-zero even for a limit of 0
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
    localparam int unsigned BW = $clog2(MAX_BURST + 2);

    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;
    owner_e        owner_q, owner_d;
    logic          yield_q, yield_d;
    logic [15:0]   stall_q, stall_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    logic starve_hit;
    logic lock_hold;
    logic ext_win;
    logic core_win;

    // Grant decision: starvation beats everything, lock beats core until the burst limit.
    // A lock survives the single core cycle forced by the burst limit (yield_q).
    always_comb begin
        starve_hit = ext_req && (starve_q == SW'(STARVE_LIMIT));
        lock_hold  = ext_req && ext_lock && ((owner_q == OwnerExt) || yield_q)
                     && (burst_q < BW'(MAX_BURST));
        ext_win    = ext_req && (!core_req || starve_hit || lock_hold);
        core_win   = core_req && !ext_win;
        owner_d    = OwnerNone;
        if (ext_win) begin
            owner_d = OwnerExt;
        end else if (core_win) begin
            owner_d = OwnerCore;
        end
    end

    // Route the owner's request onto the memory port; idle port is fully zeroed.
    always_comb begin
        mem_we0      = 1'b0;
        mem_rd_addr0 = '0;
        mem_wr_addr0 = '0;
        mem_wr_din0  = '0;
        mem_wr_strb  = '0;
        unique case (owner_d)
            OwnerCore: begin
                mem_we0      = core_we;
                mem_rd_addr0 = core_addr;
                mem_wr_addr0 = core_addr;
                mem_wr_din0  = core_wdata;
                mem_wr_strb  = core_strb;
            end
            OwnerExt: begin
                mem_we0      = ext_we;
                mem_rd_addr0 = ext_addr;
                mem_wr_addr0 = ext_addr;
                mem_wr_din0  = ext_wdata;
                mem_wr_strb  = ext_strb;
            end
            default: ;
        endcase
    end

    // Next-state for counters, yield flag and the registered ext read response.
    always_comb begin
        starve_d = '0;
        burst_d  = '0;
        yield_d  = 1'b0;
        stall_d  = stall_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        if (ext_req && !ext_win) begin
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
        end

        if (ext_win) begin
            burst_d = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + 1'b1;
        end

        // Core took ext's slot only because the burst ran out
        yield_d = core_win && ext_req && (burst_q >= BW'(MAX_BURST));

        if (core_stall && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        if (ext_win && !ext_we) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_rd_dout0;
        end
    end

    // State registers; reset drops any pending response and restarts arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            burst_q  <= '0;
            owner_q  <= OwnerNone;
            yield_q  <= 1'b0;
            stall_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            burst_q  <= burst_d;
            owner_q  <= owner_d;
            yield_q  <= yield_d;
            stall_q  <= stall_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Outputs
    always_comb begin
        ext_gnt     = ext_win;
        core_stall  = core_req && !core_win;
        core_rdata  = mem_rd_dout0;
        ext_rdata   = rdata_q;
        ext_rvalid  = rvalid_q;
        stall_count = stall_q;
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: reset-time vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_datamem_arbiter;
    import datamem_pkg::*;

    localparam int Starve = 4;
    localparam int MaxB   = 8;

    logic        clk;
    logic        rst;
    logic        core_req, core_we;
    logic [6:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_strb;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        ext_req, ext_we, ext_lock;
    logic [6:0]  ext_addr;
    logic [31:0] ext_wdata;
    logic [2:0]  ext_strb;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        ext_rvalid;
    logic        mem_we0;
    logic [6:0]  mem_rd_addr0, mem_wr_addr0;
    logic [31:0] mem_wr_din0;
    logic [2:0]  mem_wr_strb;
    logic [31:0] mem_rd_dout0;
    logic [15:0] stall_count;

    datamem_arbiter #(.STARVE_LIMIT(Starve), .MAX_BURST(MaxB)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_strb(core_strb),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_strb(ext_strb),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .mem_we0(mem_we0), .mem_rd_addr0(mem_rd_addr0), .mem_wr_addr0(mem_wr_addr0),
        .mem_wr_din0(mem_wr_din0), .mem_wr_strb(mem_wr_strb), .mem_rd_dout0(mem_rd_dout0),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          m_wait;      // cycles ext has been waiting
    int          m_run;       // consecutive ext grants
    int          m_stalls;    // unsaturated stall total
    bit          m_prev_ext;  // ext owned last cycle
    bit          m_yield;     // last cycle was the core's forced slot inside a burst
    bit          m_rvalid;
    logic [31:0] m_rdata;
    bit          m_check_en;

    task automatic m_reset();
        m_wait = 0; m_run = 0; m_stalls = 0;
        m_prev_ext = 0; m_yield = 0; m_rvalid = 0; m_rdata = 32'h0;
    endtask

    function automatic bit m_ext_wins();
        if (!ext_req) return 1'b0;
        if (!core_req) return 1'b1;
        if (m_wait >= Starve) return 1'b1;
        return ext_lock && (m_prev_ext || m_yield) && (m_run < MaxB);
    endfunction

    task automatic check_model();
        bit          ew, cw;
        logic        we;
        logic [6:0]  a;
        logic [31:0] d;
        logic [2:0]  s;
        ew = m_ext_wins();
        cw = core_req && !ew;
        we = 1'b0; a = '0; d = '0; s = '0;
        if (ew) begin
            we = ext_we; a = ext_addr; d = ext_wdata; s = ext_strb;
        end else if (cw) begin
            we = core_we; a = core_addr; d = core_wdata; s = core_strb;
        end
        chk("m.ext_gnt", 32'(ext_gnt), 32'(ew));
        chk("m.core_stall", 32'(core_stall), 32'(core_req && !cw));
        chk("m.mem_we0", 32'(mem_we0), 32'(we));
        chk("m.rd_addr", 32'(mem_rd_addr0), 32'(a));
        chk("m.wr_addr", 32'(mem_wr_addr0), 32'(a));
        chk("m.wr_din", mem_wr_din0, d);
        chk("m.wr_strb", 32'(mem_wr_strb), 32'(s));
        chk("m.core_rdata", core_rdata, mem_rd_dout0);
        chk("m.ext_rvalid", 32'(ext_rvalid), 32'(m_rvalid));
        chk("m.ext_rdata", ext_rdata, m_rdata);
        chk("m.stall_count", 32'(stall_count), (m_stalls > 65535) ? 32'hFFFF : 32'(m_stalls));
    endtask

    task automatic m_commit();
        bit ew, cw;
        ew = m_ext_wins();
        cw = core_req && !ew;
        m_yield    = cw && ext_req && (m_run >= MaxB);
        m_wait     = (ext_req && !ew) ? m_wait + 1 : 0;
        m_run      = ew ? m_run + 1 : 0;
        m_prev_ext = ew;
        if (core_req && !cw) m_stalls++;
        m_rvalid = ew && !ext_we;
        if (m_rvalid) m_rdata = mem_rd_dout0;
    endtask

    // Called 1 time unit after inputs change; leaves time at posedge+1.
    task automatic clk_step();
        if (m_check_en) check_model();
        @(posedge clk);
        m_commit();
        #1;
    endtask

    task automatic set_idle();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_strb = '0;
        ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0; ext_strb = '0;
        mem_rd_dout0 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- reset-time vector table ----------------
    typedef struct {
        logic        creq, cwe;
        logic [6:0]  caddr;
        logic [31:0] cwd;
        logic [2:0]  cstrb;
        logic        ereq, ewe, elock;
        logic [6:0]  eaddr;
        logic [31:0] ewd;
        logic [2:0]  estrb;
        logic [31:0] dout;
        logic        x_stall, x_gnt, x_we;
        logic [6:0]  x_addr;
        logic [31:0] x_din;
        logic [2:0]  x_strb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [5:0]  pat6;
        logic [11:0] gnt12, stl12;

        vecs[0] = '{1'b1, 1'b1, 7'h05, 32'hDEADBEEF, StrbWord,
                    1'b0, 1'b0, 1'b0, 7'h00, 32'h0, StrbWord, 32'h11111111,
                    1'b0, 1'b0, 1'b1, 7'h05, 32'hDEADBEEF, StrbWord};
        vecs[1] = '{1'b0, 1'b1, 7'h22, 32'hCAFEF00D, StrbByte1,
                    1'b1, 1'b0, 1'b0, 7'h10, 32'hA5A5A5A5, StrbByte1, 32'h22222222,
                    1'b0, 1'b1, 1'b0, 7'h10, 32'hA5A5A5A5, StrbByte1};
        vecs[2] = '{1'b1, 1'b0, 7'h7F, 32'h01234567, StrbHalfHi,
                    1'b1, 1'b1, 1'b1, 7'h33, 32'h89ABCDEF, StrbWord, 32'h33333333,
                    1'b0, 1'b0, 1'b0, 7'h7F, 32'h01234567, StrbHalfHi};
        vecs[3] = '{1'b0, 1'b1, 7'h44, 32'hFFFFFFFF, StrbByte3,
                    1'b0, 1'b1, 1'b1, 7'h55, 32'hEEEEEEEE, StrbByte2, 32'h44444444,
                    1'b0, 1'b0, 1'b0, 7'h00, 32'h0, StrbWord};
        vecs[4] = '{1'b0, 1'b0, 7'h01, 32'h0, StrbWord,
                    1'b1, 1'b1, 1'b0, 7'h7E, 32'h000000AB, StrbByte0, 32'h55555555,
                    1'b0, 1'b1, 1'b1, 7'h7E, 32'h000000AB, StrbByte0};
        vecs[5] = '{1'b1, 1'b1, 7'h40, 32'h0000BEEF, StrbHalfLo,
                    1'b0, 1'b0, 1'b1, 7'h12, 32'h12121212, StrbByte2, 32'h66666666,
                    1'b0, 1'b0, 1'b1, 7'h40, 32'h0000BEEF, StrbHalfLo};

        m_check_en = 1'b0;
        set_idle();
        m_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst.stall_count", 32'(stall_count), 32'h0);
        chk("rst.ext_rvalid", 32'(ext_rvalid), 32'h0);
        chk("rst.ext_rdata", ext_rdata, 32'h0);

        // Combinational routing with all state held at reset values
        for (int i = 0; i < 6; i++) begin
            core_req = vecs[i].creq; core_we = vecs[i].cwe; core_addr = vecs[i].caddr;
            core_wdata = vecs[i].cwd; core_strb = vecs[i].cstrb;
            ext_req = vecs[i].ereq; ext_we = vecs[i].ewe; ext_lock = vecs[i].elock;
            ext_addr = vecs[i].eaddr; ext_wdata = vecs[i].ewd; ext_strb = vecs[i].estrb;
            mem_rd_dout0 = vecs[i].dout;
            #1;
            chk($sformatf("vec%0d.core_stall", i), 32'(core_stall), 32'(vecs[i].x_stall));
            chk($sformatf("vec%0d.ext_gnt", i), 32'(ext_gnt), 32'(vecs[i].x_gnt));
            chk($sformatf("vec%0d.mem_we0", i), 32'(mem_we0), 32'(vecs[i].x_we));
            chk($sformatf("vec%0d.rd_addr", i), 32'(mem_rd_addr0), 32'(vecs[i].x_addr));
            chk($sformatf("vec%0d.wr_addr", i), 32'(mem_wr_addr0), 32'(vecs[i].x_addr));
            chk($sformatf("vec%0d.wr_din", i), mem_wr_din0, vecs[i].x_din);
            chk($sformatf("vec%0d.wr_strb", i), 32'(mem_wr_strb), 32'(vecs[i].x_strb));
            chk($sformatf("vec%0d.core_rdata", i), core_rdata, vecs[i].dout);
        end

        m_check_en = 1'b1;

        // Starvation: both requesting, ext wins only on the fifth cycle
        do_reset();
        pat6 = 6'b010000;
        core_req = 1; core_addr = 7'h03; ext_req = 1; ext_we = 1; ext_addr = 7'h09;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("starve.c%0d.ext_gnt", c + 1), 32'(ext_gnt), 32'(pat6[c]));
            chk($sformatf("starve.c%0d.core_stall", c + 1), 32'(core_stall), 32'(pat6[c]));
            clk_step();
        end
        #1;
        chk("starve.stall_count", 32'(stall_count), 32'd1);
        clk_step();

        // Locked burst: 8 ext grants, one core slot, then ext resumes
        do_reset();
        gnt12 = 12'b1110_1111_1111;
        stl12 = 12'b1110_1111_1110;
        ext_req = 1; ext_lock = 1; ext_we = 1; ext_addr = 7'h20; core_addr = 7'h01;
        for (int c = 0; c < 12; c++) begin
            core_req = (c != 0);
            #1;
            chk($sformatf("burst.c%0d.ext_gnt", c + 1), 32'(ext_gnt), 32'(gnt12[c]));
            chk($sformatf("burst.c%0d.core_stall", c + 1), 32'(core_stall), 32'(stl12[c]));
            clk_step();
        end

        // Ext read: response one cycle later, held afterwards
        do_reset();
        ext_req = 1; ext_we = 0; ext_addr = 7'h10; mem_rd_dout0 = 32'h12345678;
        #1;
        chk("rd.ext_gnt", 32'(ext_gnt), 32'h1);
        chk("rd.rd_addr", 32'(mem_rd_addr0), 32'h10);
        chk("rd.rvalid_early", 32'(ext_rvalid), 32'h0);
        clk_step();
        ext_req = 0; mem_rd_dout0 = 32'hDEADDEAD;
        #1;
        chk("rd.rvalid", 32'(ext_rvalid), 32'h1);
        chk("rd.rdata", ext_rdata, 32'h12345678);
        clk_step();
        #1;
        chk("rd.rvalid_once", 32'(ext_rvalid), 32'h0);
        chk("rd.rdata_hold", ext_rdata, 32'h12345678);
        clk_step();

        // Reset in the middle of a locked read burst
        do_reset();
        ext_req = 1; ext_lock = 1; ext_we = 0; ext_addr = 7'h30; mem_rd_dout0 = 32'h0BADF00D;
        for (int c = 0; c < 3; c++) begin
            core_req = (c != 0);
            #1;
            clk_step();
        end
        #1;
        chk("mid.rvalid_pending", 32'(ext_rvalid), 32'h1);
        chk("mid.stall_before", 32'(stall_count), 32'd2);
        rst = 1'b0;
        m_reset();
        #1;
        chk("mid.rvalid", 32'(ext_rvalid), 32'h0);
        chk("mid.rdata", ext_rdata, 32'h0);
        chk("mid.stall_count", 32'(stall_count), 32'h0);
        chk("mid.in_rst_ext_gnt", 32'(ext_gnt), 32'h0);
        chk("mid.in_rst_core_stall", 32'(core_stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid.after_ext_gnt", 32'(ext_gnt), 32'h0);
        chk("mid.after_core_stall", 32'(core_stall), 32'h0);
        clk_step();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            core_req = ($urandom_range(0, 9) < 7);
            core_we = $urandom_range(0, 1); core_addr = 7'($urandom);
            core_wdata = $urandom; core_strb = 3'($urandom);
            ext_req = ($urandom_range(0, 9) < 7);
            ext_we = $urandom_range(0, 1); ext_lock = ($urandom_range(0, 9) < 6);
            ext_addr = 7'($urandom); ext_wdata = $urandom; ext_strb = 3'($urandom);
            mem_rd_dout0 = $urandom;
            #1;
            clk_step();
        end

        // Stall counter saturation under long locked contention
        do_reset();
        m_check_en = 1'b0;
        core_req = 1; ext_req = 1; ext_lock = 1; ext_we = 1;
        for (int c = 0; c < 74000; c++) begin
            #1;
            clk_step();
        end
        #1;
        chk("sat.model_enough", 32'(m_stalls > 65535), 32'h1);
        chk("sat.stall_count", 32'(stall_count), 32'h0000FFFF);
        m_check_en = 1'b1;
        clk_step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
